// File: rtl/arbitro_unidad_desplazamiento.sv
// Round-robin arbiter that shares one rotate/shift datapath among NUM_SOL requesters.
// Optional ENTREGA timeout with a one-cycle Error pulse: define TIEMPO_LIMITE_ENTREGA_EN.
module arbitro_unidad_desplazamiento #(
  parameter int NUM_SOL       = 4,
  parameter int ANCHO         = 8,
  parameter int LATENCIA      = 2,
  parameter int TIEMPO_LIMITE = 15
) (
  input  logic                     Reloj,
  input  logic                     ResetN,
  input  logic [NUM_SOL-1:0]       Solicitud,
  input  logic [2*NUM_SOL-1:0]     Operacion,
  input  logic [NUM_SOL*ANCHO-1:0] Datos,
  input  logic                     Acepta,
  output logic [ANCHO-1:0]         PalabraUnidad,
  input  logic [ANCHO-1:0]         RtaRota,
  input  logic [ANCHO-1:0]         RtaDesplaza,
  output logic [NUM_SOL-1:0]       Concesion,
  output logic [ANCHO-1:0]         Resultado,
  output logic                     Valido,
  output logic                     Ocupado,
  output logic                     Error
);

  localparam int PW = (NUM_SOL > 1) ? $clog2(NUM_SOL) : 1;
  localparam int CW = $clog2(LATENCIA + 1);

  typedef enum logic [1:0] {LIBRE, ESPERA, ENTREGA} estado_t;

  estado_t              r_estado,    w_estado;
  logic [PW-1:0]        r_puntero,   w_puntero;
  logic [PW-1:0]        r_ganador,   w_ganador;
  logic [CW-1:0]        r_contador,  w_contador;
  logic [1:0]           r_op,        w_op;
  logic [ANCHO-1:0]     r_palabra,   w_palabra;
  logic [NUM_SOL-1:0]   r_concesion, w_concesion;
  logic [ANCHO-1:0]     r_resultado, w_resultado;
  logic                 r_valido,    w_valido;
  logic                 r_ocupado;
  logic                 w_hay_solicitud;
  logic [PW-1:0]        w_idx_ganador;

`ifdef TIEMPO_LIMITE_ENTREGA_EN
  localparam int TW = $clog2(TIEMPO_LIMITE + 1);
  logic [TW-1:0] r_limite;
  logic          r_error, w_error;
`endif

  // Scan downward so the lowest offset from the pointer is written last and wins.
  always_comb begin
    int            idx;
    logic [PW-1:0] v_idx;
    idx             = 0;
    v_idx           = '0;
    w_hay_solicitud = 1'b0;
    w_idx_ganador   = '0;
    for (int k = NUM_SOL - 1; k >= 0; k--) begin
      idx = int'(r_puntero) + k;
      if (idx >= NUM_SOL) idx = idx - NUM_SOL;
      v_idx = PW'(idx);
      if (Solicitud[v_idx]) begin
        w_hay_solicitud = 1'b1;
        w_idx_ganador   = v_idx;
      end
    end
  end

  // NOTE: every output of this block is given a default first, so no path leaves a latch.
  always_comb begin
    w_estado    = r_estado;
    w_puntero   = r_puntero;
    w_ganador   = r_ganador;
    w_contador  = r_contador;
    w_op        = r_op;
    w_palabra   = r_palabra;
    w_concesion = r_concesion;
    w_resultado = r_resultado;
    w_valido    = r_valido;
`ifdef TIEMPO_LIMITE_ENTREGA_EN
    w_error     = 1'b0;
`endif
    case (r_estado)
      LIBRE: begin
        if (w_hay_solicitud) begin
          w_ganador   = w_idx_ganador;
          w_concesion = NUM_SOL'(1) << w_idx_ganador;
          w_palabra   = Datos[w_idx_ganador*ANCHO +: ANCHO];
          w_op        = Operacion[2*w_idx_ganador +: 2];
          w_contador  = CW'(LATENCIA - 1);
          w_estado    = ESPERA;
        end
      end
      ESPERA: begin
        if (r_contador != '0) begin
          w_contador = r_contador - 1'b1;
        end else begin
          case (r_op)
            2'b00:   w_resultado = RtaRota;
            2'b01:   w_resultado = RtaDesplaza;
            2'b10:   w_resultado = r_palabra;
            default: w_resultado = ~r_palabra;
          endcase
          w_valido = 1'b1;
          w_estado = ENTREGA;
        end
      end
      ENTREGA: begin
        if (Acepta) begin
          w_valido    = 1'b0;
          w_concesion = '0;
          w_puntero   = (r_ganador == PW'(NUM_SOL - 1)) ? '0 : r_ganador + 1'b1;
          w_estado    = LIBRE;
        end
`ifdef TIEMPO_LIMITE_ENTREGA_EN
        else if (r_limite == TW'(TIEMPO_LIMITE - 1)) begin
          // Abandoned result: drop it and move past this requester.
          w_valido    = 1'b0;
          w_concesion = '0;
          w_puntero   = (r_ganador == PW'(NUM_SOL - 1)) ? '0 : r_ganador + 1'b1;
          w_error     = 1'b1;
          w_estado    = LIBRE;
        end
`endif
      end
      default: w_estado = LIBRE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Reloj) begin
    if (!ResetN) begin
      r_estado    <= LIBRE;
      r_puntero   <= '0;
      r_ganador   <= '0;
      r_contador  <= '0;
      r_op        <= '0;
      r_palabra   <= '0;
      r_concesion <= '0;
      r_resultado <= '0;
      r_valido    <= 1'b0;
      r_ocupado   <= 1'b0;
    end else begin
      r_estado    <= w_estado;
      r_puntero   <= w_puntero;
      r_ganador   <= w_ganador;
      r_contador  <= w_contador;
      r_op        <= w_op;
      r_palabra   <= w_palabra;
      r_concesion <= w_concesion;
      r_resultado <= w_resultado;
      r_valido    <= w_valido;
      r_ocupado   <= (w_estado != LIBRE);
    end
  end

`ifdef TIEMPO_LIMITE_ENTREGA_EN
  always_ff @(posedge Reloj) begin
    if (!ResetN) begin
      r_limite <= '0;
      r_error  <= 1'b0;
    end else begin
      r_limite <= (r_estado == ENTREGA && w_estado == ENTREGA) ? r_limite + 1'b1 : '0;
      r_error  <= w_error;
    end
  end
  assign Error = r_error;
`else
  assign Error = 1'b0;
`endif

  assign PalabraUnidad = r_palabra;
  assign Concesion     = r_concesion;
  assign Resultado     = r_resultado;
  assign Valido        = r_valido;
  assign Ocupado       = r_ocupado;

endmodule

// File: tb/tb_arbitro_unidad_desplazamiento.sv
// Directed bench for arbitro_unidad_desplazamiento: vector table plus hand-written
// sequences for reset, fairness, hold, reset-in-flight and (if enabled) timeout.
module tb_arbitro_unidad_desplazamiento;

  localparam int NS  = 4;
  localparam int AN  = 8;
  localparam int LAT = 2;
  localparam int TL  = 15;

  logic              Reloj = 1'b0;
  logic              ResetN;
  logic [NS-1:0]     Solicitud;
  logic [2*NS-1:0]   Operacion;
  logic [NS*AN-1:0]  Datos;
  logic              Acepta;
  logic [AN-1:0]     PalabraUnidad;
  logic [AN-1:0]     RtaRota;
  logic [AN-1:0]     RtaDesplaza;
  logic [NS-1:0]     Concesion;
  logic [AN-1:0]     Resultado;
  logic              Valido;
  logic              Ocupado;
  logic              Error;

  int n_asserts = 0;
  int n_fail    = 0;

  arbitro_unidad_desplazamiento #(
    .NUM_SOL(NS), .ANCHO(AN), .LATENCIA(LAT), .TIEMPO_LIMITE(TL)
  ) dut (
    .Reloj(Reloj), .ResetN(ResetN), .Solicitud(Solicitud), .Operacion(Operacion),
    .Datos(Datos), .Acepta(Acepta), .PalabraUnidad(PalabraUnidad),
    .RtaRota(RtaRota), .RtaDesplaza(RtaDesplaza), .Concesion(Concesion),
    .Resultado(Resultado), .Valido(Valido), .Ocupado(Ocupado), .Error(Error)
  );

  // Behavioural stand-ins for the shared rotate-left-2 and shift-right-2 units.
  assign RtaRota     = {PalabraUnidad[5:0], PalabraUnidad[7:6]};
  assign RtaDesplaza = PalabraUnidad >> 2;

  always #5 Reloj = ~Reloj;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge Reloj);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_asserts++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  typedef struct {
    int         sol;
    logic [1:0] op;
    logic [7:0] dat;
    logic [7:0] res;
  } vec_t;

  vec_t vecs[7];

  // Single-requester transaction: grant, LATENCIA settle, result, accept.
  task automatic run_vec(input int n, input vec_t v);
    Solicitud = NS'(1 << v.sol);
    Datos     = $urandom;
    Datos[v.sol*AN +: AN] = v.dat;
    Operacion = 8'($urandom);
    Operacion[2*v.sol +: 2] = v.op;
    Acepta    = 1'b0;
    tick();
    check($sformatf("v%0d_grant", n), 32'(Concesion), 32'(1 << v.sol));
    check($sformatf("v%0d_ocupado", n), 32'(Ocupado), 32'd1);
    // Request withdrawn and other inputs scrambled: transaction must still complete.
    Solicitud = '0;
    Datos     = $urandom;
    Operacion = 8'($urandom);
    tick();
    check($sformatf("v%0d_valido_early", n), 32'(Valido), 32'd0);
    tick();
    check($sformatf("v%0d_valido", n), 32'(Valido), 32'd1);
    check($sformatf("v%0d_resultado", n), 32'(Resultado), 32'(v.res));
    Acepta = 1'b1;
    tick();
    check($sformatf("v%0d_valido_drop", n), 32'(Valido), 32'd0);
    check($sformatf("v%0d_concesion_drop", n), 32'(Concesion), 32'd0);
    check($sformatf("v%0d_ocupado_drop", n), 32'(Ocupado), 32'd0);
    Acepta = 1'b0;
  endtask

  initial begin
    logic [NS-1:0] exp_seq[5];
    logic [NS-1:0] prev;
    int g, last, k;

    vecs[0] = '{0, 2'b00, 8'b1000_0001, 8'b0000_0110};
    vecs[1] = '{3, 2'b01, 8'hB4, 8'h2D};
    vecs[2] = '{3, 2'b11, 8'hB4, 8'h4B};
    vecs[3] = '{3, 2'b10, 8'hB4, 8'hB4};
    vecs[4] = '{1, 2'b00, 8'hC3, 8'h0F};
    vecs[5] = '{2, 2'b01, 8'hFF, 8'h3F};
    vecs[6] = '{2, 2'b11, 8'h00, 8'hFF};
    exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b0100;
    exp_seq[3] = 4'b1000; exp_seq[4] = 4'b0001;

    // Reset with random inputs for two edges.
    ResetN = 1'b0;
    for (int i = 0; i < 2; i++) begin
      Solicitud = NS'($urandom);
      Operacion = 8'($urandom);
      Datos     = $urandom;
      Acepta    = 1'($urandom);
      tick();
    end
    check("rst_concesion", 32'(Concesion), 32'd0);
    check("rst_resultado", 32'(Resultado), 32'd0);
    check("rst_valido", 32'(Valido), 32'd0);
    check("rst_palabra", 32'(PalabraUnidad), 32'd0);
    check("rst_ocupado", 32'(Ocupado), 32'd0);
    check("rst_error", 32'(Error), 32'd0);

    // Fairness: all requesting, Acepta tied high; grants every LAT+2 edges.
    ResetN    = 1'b1;
    Solicitud = 4'b1111;
    Operacion = '0;
    Acepta    = 1'b1;
    g = 0; last = 0; prev = '0;
    for (int e = 1; e <= 40 && g < 5; e++) begin
      tick();
      if (Concesion != '0 && prev == '0) begin
        check($sformatf("fair_grant%0d", g), 32'(Concesion), 32'(exp_seq[g]));
        if (g > 0) check($sformatf("fair_gap%0d", g), 32'(e - last), 32'(LAT + 2));
        else       check("fair_first_edge", 32'(e), 32'd1);
        last = e;
        g++;
      end
      prev = Concesion;
    end
    check("fair_count", 32'(g), 32'd5);
    k = 0;
    while (Concesion != '0 && k < 20) begin tick(); k++; end
    check("fair_release", 32'(Concesion), 32'd0);

    // Hold: requester 1 is next; its result must stay put while Acepta is low.
    Acepta = 1'b0;
    Datos[15:8]    = 8'h5A;
    Operacion[3:2] = 2'b11;
    k = 0;
    while (Valido !== 1'b1 && k < 20) begin tick(); k++; end
    check("hold_valido", 32'(Valido), 32'd1);
    check("hold_concesion", 32'(Concesion), 32'b0010);
    check("hold_resultado", 32'(Resultado), 32'hA5);
    for (int i = 0; i < 5; i++) begin
      Datos = $urandom;
      tick();
      check($sformatf("hold_stable%0d", i), {Resultado, 7'd0, Valido, 12'd0, Concesion},
            {8'hA5, 7'd0, 1'b1, 12'd0, 4'b0010});
    end
    Acepta = 1'b1;
    tick();
    check("hold_accept_valido", 32'(Valido), 32'd0);
    Acepta = 1'b0;

    // Reset during ESPERA: requester 2 granted, then discarded; pointer back to 0.
    tick();
    check("rw_grant", 32'(Concesion), 32'b0100);
    check("rw_espera", 32'(Valido), 32'd0);
    ResetN = 1'b0;
    tick();
    check("rw_concesion", 32'(Concesion), 32'd0);
    check("rw_ocupado", 32'(Ocupado), 32'd0);
    check("rw_palabra", 32'(PalabraUnidad), 32'd0);
    ResetN = 1'b1;
    tick();
    check("rw_pointer0", 32'(Concesion), 32'b0001);

    // Clean restart, then the vector table.
    Solicitud = '0;
    ResetN = 1'b0;
    tick();
    ResetN = 1'b1;
    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

`ifdef TIEMPO_LIMITE_ENTREGA_EN
    // Timeout: Acepta never comes; Error pulses after TL ENTREGA edges.
    Solicitud = 4'b1111;
    Acepta    = 1'b0;
    ResetN = 1'b0;
    tick();
    ResetN = 1'b1;
    k = 0;
    while (Valido !== 1'b1 && k < 20) begin tick(); k++; end
    check("to_valido", 32'(Valido), 32'd1);
    k = 0;
    while (Error !== 1'b1 && k < 40) begin tick(); k++; end
    check("to_edges", 32'(k), 32'(TL));
    check("to_valido_drop", 32'(Valido), 32'd0);
    check("to_concesion_drop", 32'(Concesion), 32'd0);
    tick();
    check("to_error_pulse", 32'(Error), 32'd0);
    check("to_next_grant", 32'(Concesion), 32'b0010);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
